// File: rtl/move_scheduler_if.sv
// Request/response bundle between the input sources, the game logic and move_scheduler.
interface move_scheduler_if;
  logic [3:0] btn_req;
  logic [3:0] pad_req;
  logic       pad_present;
  logic [3:0] dbg_req;
  logic       welcome_active;
  logic       frame_tick;
  logic       logic_done;
  logic [3:0] move_strobe;
  logic       move_is_debug;
  logic       start_game;
  logic       dropped;
  logic       timeout;
  logic       busy;
  logic [2:0] queue_count;

  modport master (
    output btn_req, pad_req, pad_present, dbg_req, welcome_active, frame_tick, logic_done,
    input  move_strobe, move_is_debug, start_game, dropped, timeout, busy, queue_count
  );

  modport slave (
    input  btn_req, pad_req, pad_present, dbg_req, welcome_active, frame_tick, logic_done,
    output move_strobe, move_is_debug, start_game, dropped, timeout, busy, queue_count
  );
endinterface

// File: rtl/move_scheduler.sv
// Edge-detects and arbitrates move requests, queues them, and issues one strobe per move
// with a completion wait and a frame-based holdoff.
module move_scheduler #(
  parameter int unsigned QUEUE_DEPTH    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4095,
  parameter int unsigned HOLDOFF_FRAMES = 1
) (
  input logic             clk,
  input logic             rst_n,
  move_scheduler_if.slave bus
);
  localparam int unsigned AW          = (QUEUE_DEPTH > 2) ? 2 : 1;
  localparam logic [11:0] TimeoutLast = 12'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  HoldoffLoad = 2'(HOLDOFF_FRAMES);
  localparam logic [2:0]  DepthCount  = 3'(QUEUE_DEPTH);

  typedef enum logic [1:0] {StIdle, StWaitDone, StHoldoff} state_e;

  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    if (v[0]) return 2'd0;
    if (v[1]) return 2'd1;
    if (v[2]) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic more_than_one(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

  logic [3:0] btn_prev_q, pad_prev_q, pad_eff, btn_new, pad_new;
  logic       btn_any, pad_any, dbg_any;

  // An absent gamepad reads as released so its edge history restarts cleanly.
  assign pad_eff = bus.pad_present ? bus.pad_req : 4'b0000;
  assign btn_new = bus.btn_req & ~btn_prev_q;
  assign pad_new = pad_eff & ~pad_prev_q;
  assign btn_any = |btn_new;
  assign pad_any = |pad_new;
  assign dbg_any = |bus.dbg_req;

  logic       req_valid, lost, start_d;
  logic [2:0] req_entry;

  always_comb begin
    req_valid = 1'b0;
    req_entry = 3'b000;
    lost      = 1'b0;
    start_d   = bus.welcome_active && (btn_any || pad_any);
    if (dbg_any) begin
      req_valid = 1'b1;
      req_entry = {1'b1, lowest_idx(bus.dbg_req)};
      lost      = more_than_one(bus.dbg_req) || (!bus.welcome_active && (btn_any || pad_any));
    end else if (!bus.welcome_active && btn_any) begin
      req_valid = 1'b1;
      req_entry = {1'b0, lowest_idx(btn_new)};
      lost      = more_than_one(btn_new) || pad_any;
    end else if (!bus.welcome_active && pad_any) begin
      req_valid = 1'b1;
      req_entry = {1'b0, lowest_idx(pad_new)};
      lost      = more_than_one(pad_new);
    end
  end

  logic [2:0]    mem_q [QUEUE_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0]    count_q, count_d, head;
  logic          push, pop, full;
  state_e        state_q, state_d;

  assign head    = mem_q[rd_ptr_q];
  assign full    = (count_q == DepthCount);
  assign pop     = (state_q == StIdle) && (count_q != 3'd0);
  // A simultaneous pop frees the head slot, so a push into a full queue still fits.
  assign push    = req_valid && (!full || pop);
  assign count_d = count_q + {2'b00, push} - {2'b00, pop};

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= req_entry;
  end

  logic [11:0] tcnt_q, tcnt_d;
  logic [1:0]  fcnt_q, fcnt_d;
  logic [3:0]  strobe_d;
  logic        is_debug_d, timeout_d, busy_d, dropped_d;

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    fcnt_d     = fcnt_q;
    strobe_d   = 4'b0000;
    is_debug_d = 1'b0;
    timeout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          strobe_d   = 4'b0001 << head[1:0];
          is_debug_d = head[2];
          tcnt_d     = 12'd0;
          state_d    = StWaitDone;
        end
      end
      StWaitDone: begin
        if (bus.logic_done || (tcnt_q == TimeoutLast)) begin
          timeout_d = !bus.logic_done;
          fcnt_d    = HoldoffLoad;
          state_d   = (HoldoffLoad == 2'd0) ? StIdle : StHoldoff;
        end else begin
          tcnt_d = tcnt_q + 12'd1;
        end
      end
      StHoldoff: begin
        if (bus.frame_tick) begin
          fcnt_d = fcnt_q - 2'd1;
          if (fcnt_q == 2'd1) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_d    = (state_d != StIdle) || (count_d != 3'd0);
  assign dropped_d = lost || (req_valid && !push);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_prev_q        <= 4'b1111;
      pad_prev_q        <= 4'b1111;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= 3'd0;
      state_q           <= StIdle;
      tcnt_q            <= 12'd0;
      fcnt_q            <= 2'd0;
      bus.move_strobe   <= 4'b0000;
      bus.move_is_debug <= 1'b0;
      bus.start_game    <= 1'b0;
      bus.dropped       <= 1'b0;
      bus.timeout       <= 1'b0;
      bus.busy          <= 1'b0;
    end else begin
      btn_prev_q        <= bus.btn_req;
      pad_prev_q        <= pad_eff;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q           <= count_d;
      state_q           <= state_d;
      tcnt_q            <= tcnt_d;
      fcnt_q            <= fcnt_d;
      bus.move_strobe   <= strobe_d;
      bus.move_is_debug <= is_debug_d;
      bus.start_game    <= start_d;
      bus.dropped       <= dropped_d;
      bus.timeout       <= timeout_d;
      bus.busy          <= busy_d;
    end
  end

  assign bus.queue_count = count_q;
endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: depth 2, 8-cycle timeout, one holdoff frame.
module tb_move_scheduler;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   strobe_cnt;

  move_scheduler_if bus ();

  move_scheduler #(
    .QUEUE_DEPTH   (2),
    .TIMEOUT_CYCLES(8),
    .HOLDOFF_FRAMES(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.move_strobe !== 4'b0000) strobe_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic finish_move();
    bus.logic_done = 1'b1; tick(1); bus.logic_done = 1'b0;
    bus.frame_tick = 1'b1; tick(1); bus.frame_tick = 1'b0;
  endtask

  function automatic logic [11:0] all_outs();
    return {bus.move_strobe, bus.move_is_debug, bus.start_game, bus.dropped, bus.timeout,
            bus.busy, bus.queue_count};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; tick(2);
    checks++;
    if (all_outs() !== 12'h000) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", all_outs(), 12'h000);
    end
    rst_n = 1'b1; tick(1);
  endtask

  task automatic test_single();
    int base;
    base = strobe_cnt;
    bus.btn_req = 4'b0001; tick(1);
    checks++;
    if (bus.queue_count !== 3'd1) begin
      errors++; $display("FAIL single_count: got %0d expected 1", bus.queue_count);
    end
    tick(1);
    checks++;
    if ({bus.move_strobe, bus.move_is_debug} !== 5'b00010) begin
      errors++; $display("FAIL single_strobe: got %b expected 00010",
                         {bus.move_strobe, bus.move_is_debug});
    end
    tick(1);
    checks++;
    if ({bus.move_strobe, bus.busy} !== 5'b00001) begin
      errors++; $display("FAIL single_width: got %b expected 00001", {bus.move_strobe, bus.busy});
    end
    bus.btn_req = 4'b0000; tick(1);
    bus.logic_done = 1'b1; tick(1); bus.logic_done = 1'b0;
    tick(2);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL single_holdoff_busy: got %b expected 1", bus.busy);
    end
    bus.frame_tick = 1'b1; tick(1); bus.frame_tick = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL single_idle_busy: got %b expected 0", bus.busy);
    end
    checks++;
    if (strobe_cnt - base !== 1) begin
      errors++; $display("FAIL single_strobe_count: got %0d expected 1", strobe_cnt - base);
    end
  endtask

  task automatic test_simultaneous();
    int base;
    bus.pad_present = 1'b1; tick(1);
    base = strobe_cnt;
    bus.dbg_req = 4'b0100; bus.btn_req = 4'b0010; bus.pad_req = 4'b1000; tick(1);
    bus.dbg_req = 4'b0000;
    checks++;
    if ({bus.dropped, bus.queue_count} !== 4'b1001) begin
      errors++; $display("FAIL sim_push: got %b expected 1001", {bus.dropped, bus.queue_count});
    end
    tick(1);
    checks++;
    if ({bus.move_strobe, bus.move_is_debug, bus.dropped} !== 6'b010010) begin
      errors++; $display("FAIL sim_strobe: got %b expected 010010",
                         {bus.move_strobe, bus.move_is_debug, bus.dropped});
    end
    finish_move();
    bus.btn_req = 4'b0000; bus.pad_req = 4'b0000; tick(1);
    checks++;
    if (bus.busy !== 1'b0 || strobe_cnt - base !== 1) begin
      errors++; $display("FAIL sim_single_issue: got busy %b strobes %0d expected busy 0 strobes 1",
                         bus.busy, strobe_cnt - base);
    end
    bus.btn_req = 4'b0011; tick(1);
    checks++;
    if ({bus.dropped, bus.queue_count} !== 4'b1001) begin
      errors++; $display("FAIL prio_push: got %b expected 1001", {bus.dropped, bus.queue_count});
    end
    tick(1);
    checks++;
    if (bus.move_strobe !== 4'b0001) begin
      errors++; $display("FAIL prio_strobe: got %b expected 0001", bus.move_strobe);
    end
    finish_move();
    bus.btn_req = 4'b0000; bus.pad_present = 1'b0; tick(1);
  endtask

  task automatic test_overflow();
    int base;
    base = strobe_cnt;
    bus.dbg_req = 4'b0001; tick(1); bus.dbg_req = 4'b0000;
    tick(1);
    bus.btn_req = 4'b0010; tick(1);
    bus.btn_req = 4'b0110; tick(1);
    bus.btn_req = 4'b1110; tick(1);
    checks++;
    if ({bus.dropped, bus.queue_count} !== 4'b1010) begin
      errors++; $display("FAIL ovf_full: got %b expected 1010", {bus.dropped, bus.queue_count});
    end
    tick(1);
    checks++;
    if ({bus.dropped, bus.queue_count} !== 4'b0010) begin
      errors++; $display("FAIL ovf_hold: got %b expected 0010", {bus.dropped, bus.queue_count});
    end
    bus.logic_done = 1'b1; tick(1); bus.logic_done = 1'b0;
    tick(1);
    checks++;
    if ({bus.move_strobe, bus.busy} !== 5'b00001) begin
      errors++; $display("FAIL ovf_wait_frame: got %b expected 00001", {bus.move_strobe, bus.busy});
    end
    bus.frame_tick = 1'b1; tick(1); bus.frame_tick = 1'b0;
    tick(1);
    checks++;
    if ({bus.move_strobe, bus.move_is_debug, bus.queue_count} !== 8'b0010_0_001) begin
      errors++; $display("FAIL ovf_first: got %b expected 00100001",
                         {bus.move_strobe, bus.move_is_debug, bus.queue_count});
    end
    bus.logic_done = 1'b1; tick(1); bus.logic_done = 1'b0;
    bus.frame_tick = 1'b1; tick(1); bus.frame_tick = 1'b0;
    checks++;
    if (bus.move_strobe !== 4'b0000) begin
      errors++; $display("FAIL ovf_gap: got %b expected 0000", bus.move_strobe);
    end
    tick(1);
    checks++;
    if ({bus.move_strobe, bus.queue_count} !== 7'b0100_000) begin
      errors++; $display("FAIL ovf_second: got %b expected 0100000",
                         {bus.move_strobe, bus.queue_count});
    end
    finish_move();
    bus.btn_req = 4'b0000; tick(1);
    checks++;
    if (bus.busy !== 1'b0 || strobe_cnt - base !== 3) begin
      errors++; $display("FAIL ovf_total: got busy %b strobes %0d expected busy 0 strobes 3",
                         bus.busy, strobe_cnt - base);
    end
  endtask

  task automatic test_welcome();
    int base;
    base = strobe_cnt;
    bus.welcome_active = 1'b1; tick(1);
    bus.btn_req = 4'b0100; tick(1);
    checks++;
    if ({bus.start_game, bus.queue_count, bus.busy} !== 5'b1_000_0) begin
      errors++; $display("FAIL welcome_start: got %b expected 10000",
                         {bus.start_game, bus.queue_count, bus.busy});
    end
    tick(1);
    checks++;
    if (bus.start_game !== 1'b0) begin
      errors++; $display("FAIL welcome_pulse: got %b expected 0", bus.start_game);
    end
    tick(3);
    checks++;
    if (strobe_cnt - base !== 0) begin
      errors++; $display("FAIL welcome_no_strobe: got %0d expected 0", strobe_cnt - base);
    end
    bus.dbg_req = 4'b1000; tick(1); bus.dbg_req = 4'b0000;
    tick(1);
    checks++;
    if ({bus.move_strobe, bus.move_is_debug} !== 5'b10001) begin
      errors++; $display("FAIL welcome_dbg: got %b expected 10001",
                         {bus.move_strobe, bus.move_is_debug});
    end
    finish_move();
    bus.welcome_active = 1'b0; bus.btn_req = 4'b0000; tick(1);
  endtask

  task automatic test_timeout();
    bus.dbg_req = 4'b0001; tick(1);
    bus.dbg_req = 4'b0010; tick(1); bus.dbg_req = 4'b0000;
    checks++;
    if ({bus.move_strobe, bus.queue_count} !== 7'b0001_001) begin
      errors++; $display("FAIL to_first: got %b expected 0001001", {bus.move_strobe, bus.queue_count});
    end
    tick(7);
    checks++;
    if (bus.timeout !== 1'b0) begin
      errors++; $display("FAIL to_early: got %b expected 0", bus.timeout);
    end
    tick(1);
    checks++;
    if (bus.timeout !== 1'b1) begin
      errors++; $display("FAIL to_pulse: got %b expected 1", bus.timeout);
    end
    tick(1);
    checks++;
    if ({bus.timeout, bus.move_strobe, bus.busy} !== 6'b0_0000_1) begin
      errors++; $display("FAIL to_after: got %b expected 000001",
                         {bus.timeout, bus.move_strobe, bus.busy});
    end
    bus.frame_tick = 1'b1; tick(1); bus.frame_tick = 1'b0;
    tick(1);
    checks++;
    if ({bus.move_strobe, bus.move_is_debug} !== 5'b00101) begin
      errors++; $display("FAIL to_next: got %b expected 00101", {bus.move_strobe, bus.move_is_debug});
    end
    finish_move();
  endtask

  task automatic test_reset_mid();
    int base;
    bus.dbg_req = 4'b0001; tick(1);
    bus.dbg_req = 4'b0010; tick(1); bus.dbg_req = 4'b0000;
    base = strobe_cnt;
    checks++;
    if ({bus.move_strobe, bus.queue_count} !== 7'b0001_001) begin
      errors++; $display("FAIL rst_setup: got %b expected 0001001", {bus.move_strobe, bus.queue_count});
    end
    rst_n = 1'b0; bus.btn_req = 4'b1111; tick(1);
    checks++;
    if (all_outs() !== 12'h000) begin
      errors++; $display("FAIL rst_mid_outputs: got %h expected %h", all_outs(), 12'h000);
    end
    tick(1); rst_n = 1'b1;
    tick(6);
    checks++;
    if (strobe_cnt - base !== 1 || bus.busy !== 1'b0 || bus.queue_count !== 3'd0) begin
      errors++; $display("FAIL rst_held: got strobes %0d busy %b count %0d expected 1 0 0",
                         strobe_cnt - base, bus.busy, bus.queue_count);
    end
    bus.btn_req = 4'b1110; tick(1);
    bus.btn_req = 4'b1111; tick(2);
    checks++;
    if (bus.move_strobe !== 4'b0001) begin
      errors++; $display("FAIL rst_repress: got %b expected 0001", bus.move_strobe);
    end
    finish_move();
    bus.btn_req = 4'b0000; tick(1);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL rst_final_busy: got %b expected 0", bus.busy);
    end
  endtask

  initial begin
    checks = 0; errors = 0; strobe_cnt = 0;
    rst_n = 1'b0;
    bus.btn_req = 4'b0000; bus.pad_req = 4'b0000; bus.pad_present = 1'b0;
    bus.dbg_req = 4'b0000; bus.welcome_active = 1'b0;
    bus.frame_tick = 1'b0; bus.logic_done = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_overflow();
    test_welcome();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
